// File: rtl/spu_loader_pkg.sv
// Shared definitions for the SPU program loader: header layout, target codes
// and the loader state encoding.
package spu_loader_pkg;

  typedef enum logic [1:0] {
    TGT_IMEM = 2'b00,
    TGT_RF   = 2'b01,
    TGT_LS   = 2'b10,
    TGT_END  = 2'b11
  } tgt_e;

  // Stream bit 0 is the MSB, so header field [0:1] lives in s_data[31:30].
  localparam int HDR_TGT_MSB  = 31;
  localparam int HDR_TGT_LSB  = 30;
  localparam int HDR_ADDR_MSB = 29;
  localparam int HDR_ADDR_LSB = 15;
  localparam int HDR_CNT_MSB  = 14;
  localparam int HDR_CNT_LSB  = 0;

  typedef enum logic [1:0] {
    HDR  = 2'b00,
    DATA = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/spu_line_packer.sv
// Assembles consecutive stream words into one line, first word in the MSBs.
// Only the leading words are stored; the final word completes line_nxt directly.
module spu_line_packer #(
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] word,
  output logic [LINE_W-1:0] line_nxt,
  output logic              line_full
);

  localparam int N_WORDS = LINE_W / DATA_W;
  localparam int IDX_W   = $clog2(N_WORDS);

  logic [IDX_W-1:0]         idx;
  logic [LINE_W-DATA_W-1:0] line_q;

  assign line_nxt  = {line_q, word};
  assign line_full = push && (idx == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (push) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      line_q <= {line_q[LINE_W-2*DATA_W-1:0], word};
    end
  end

endmodule

// File: rtl/spu_program_loader.sv
// Decodes a header/payload word stream into one-cycle preload writes for the
// SPU instruction memory, register file and local store; holds core_rst until END.
module spu_program_loader
  import spu_loader_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 128,
  parameter int IMEM_AW  = 10,
  parameter int RF_AW    = 10,
  parameter int RF_DEPTH = 128,
  parameter int LS_AW    = 15,
  parameter int CNT_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              load_en,
  output logic [DATA_W-1:0] instruction_in,
  output logic [IMEM_AW-1:0] instr_load_addr,
  output logic              preload_en,
  output logic [RF_AW-1:0]  preload_addr,
  output logic [LINE_W-1:0] preload_values,
  output logic              preload_LS_en,
  output logic [LS_AW-1:0]  preload_LS_addr,
  output logic [LINE_W-1:0] preload_LS_data,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int RF_NW = $clog2(RF_DEPTH);

  state_e                            state, state_nxt;
  tgt_e                              tgt;
  logic [CNT_W-1:0]                  cnt;
  logic [IMEM_AW-1:0]                imem_addr;
  logic [RF_NW-1:0]                  rf_num;
  logic                              rf_ovf;
  logic [LS_AW-1:0]                  ls_addr;

  tgt_e                              hdr_tgt;
  logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] hdr_start;
  logic [CNT_W-1:0]                  hdr_cnt;
  logic                              xfer, hdr_acc, data_acc, pack_push, entry_done;
  logic [LINE_W-1:0]                 line_nxt;
  logic                              line_full;

  assign hdr_tgt   = tgt_e'(s_data[HDR_TGT_MSB:HDR_TGT_LSB]);
  assign hdr_start = s_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];

  assign s_ready    = (state != DONE);
  assign core_rst   = (state != DONE);
  assign done       = (state == DONE);
  assign xfer       = s_valid && s_ready;
  assign hdr_acc    = xfer && (state == HDR);
  assign data_acc   = xfer && (state == DATA);
  assign pack_push  = data_acc && (tgt != TGT_IMEM);
  assign entry_done = data_acc && ((tgt == TGT_IMEM) || line_full);

  spu_line_packer #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (hdr_acc),
    .push      (pack_push),
    .word      (s_data),
    .line_nxt  (line_nxt),
    .line_full (line_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR: begin
        if (hdr_acc) begin
          if (hdr_tgt == TGT_END) begin
            state_nxt = DONE;
          end else if (hdr_cnt != '0) begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (entry_done && (cnt == CNT_W'(1))) begin
          state_nxt = HDR;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Header capture, per-entry address stepping and registered write ports
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt             <= TGT_IMEM;
      cnt             <= '0;
      imem_addr       <= '0;
      rf_num          <= '0;
      rf_ovf          <= 1'b0;
      ls_addr         <= '0;
      load_en         <= 1'b0;
      instruction_in  <= '0;
      instr_load_addr <= '0;
      preload_en      <= 1'b0;
      preload_addr    <= '0;
      preload_values  <= '0;
      preload_LS_en   <= 1'b0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
      err             <= 1'b0;
    end else begin
      load_en       <= 1'b0;
      preload_en    <= 1'b0;
      preload_LS_en <= 1'b0;
      if (hdr_acc) begin
        tgt       <= hdr_tgt;
        cnt       <= hdr_cnt;
        imem_addr <= hdr_start[IMEM_AW-1:0];
        rf_num    <= hdr_start[RF_NW-1:0];
        rf_ovf    <= 1'b0;
        ls_addr   <= {hdr_start[LS_AW-1:4], 4'b0000};
        if ((hdr_tgt == TGT_LS) && (hdr_start[3:0] != 4'b0000)) begin
          err <= 1'b1;
        end
      end
      if (entry_done) begin
        cnt <= cnt - 1'b1;
        case (tgt)
          TGT_IMEM: begin
            load_en         <= 1'b1;
            instruction_in  <= s_data;
            instr_load_addr <= imem_addr;
            imem_addr       <= imem_addr + 1'b1;
          end
          TGT_RF: begin
            // Once the register number steps past the last register, entries are dropped
            if (rf_ovf) begin
              err <= 1'b1;
            end else begin
              preload_en     <= 1'b1;
              preload_addr   <= RF_AW'(rf_num);
              preload_values <= line_nxt;
            end
            if (rf_num == RF_NW'(RF_DEPTH - 1)) begin
              rf_ovf <= 1'b1;
            end
            rf_num <= rf_num + 1'b1;
          end
          TGT_LS: begin
            preload_LS_en   <= 1'b1;
            preload_LS_addr <= ls_addr;
            preload_LS_data <= line_nxt;
            ls_addr         <= ls_addr + LS_AW'(16);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spu_program_loader.sv
// Scoreboard bench for spu_program_loader: loads are described at the header
// level, expected writes are derived arithmetically and queued for a monitor.
module tb_spu_program_loader;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         load_en;
  logic [31:0]  instruction_in;
  logic [9:0]   instr_load_addr;
  logic         preload_en;
  logic [9:0]   preload_addr;
  logic [127:0] preload_values;
  logic         preload_LS_en;
  logic [14:0]  preload_LS_addr;
  logic [127:0] preload_LS_data;
  logic         core_rst;
  logic         done;
  logic         err;

  spu_program_loader dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .load_en         (load_en),
    .instruction_in  (instruction_in),
    .instr_load_addr (instr_load_addr),
    .preload_en      (preload_en),
    .preload_addr    (preload_addr),
    .preload_values  (preload_values),
    .preload_LS_en   (preload_LS_en),
    .preload_LS_addr (preload_LS_addr),
    .preload_LS_data (preload_LS_data),
    .core_rst        (core_rst),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [41:0]  q_im[$];
  logic [137:0] q_rf[$];
  logic [142:0] q_ls[$];
  logic         exp_err;
  logic         hold_core;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (load_en) begin
        if (q_im.size() == 0) check("unexpected_load_en", 128'(instr_load_addr), 128'h1_0000);
        else check("imem_write", 128'({instr_load_addr, instruction_in}), 128'(q_im.pop_front()));
      end
      if (preload_en) begin
        if (q_rf.size() == 0) check("unexpected_preload_en", 128'(preload_addr), 128'h1_0000);
        else begin
          logic [137:0] e;
          e = q_rf.pop_front();
          check("rf_addr", 128'(preload_addr), 128'(e[137:128]));
          check("rf_values", preload_values, e[127:0]);
        end
      end
      if (preload_LS_en) begin
        if (q_ls.size() == 0) check("unexpected_ls_en", 128'(preload_LS_addr), 128'h1_0000);
        else begin
          logic [142:0] e;
          e = q_ls.pop_front();
          check("ls_addr", 128'(preload_LS_addr), 128'(e[142:128]));
          check("ls_data", preload_LS_data, e[127:0]);
        end
      end
      if (int'(load_en) + int'(preload_en) + int'(preload_LS_en) > 1)
        check("one_strobe", 128'({load_en, preload_en, preload_LS_en}), 128'h0);
      if (hold_core) check("core_rst_held", 128'(core_rst), 128'd1);
    end
  end

  function automatic logic [31:0] mk_hdr(input logic [1:0] t, input int start, input int cnt);
    logic [14:0] s;
    logic [14:0] c;
    s = 15'(start);
    c = 15'(cnt);
    return {t, s, c};
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap);
    int  n;
    bit  ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    s_data  = $urandom;
    if (!ok) check("handshake_timeout", 128'(n), 128'd0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_err = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before every word, 2 random
  task automatic run_load(input logic [1:0] t, input int start, input int cnt,
                          input int gap_mode, input bit pattern);
    int gap;
    gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
    send_word(mk_hdr(t, start, cnt), gap);
    if (t == 2'b10 && (start % 16) != 0) exp_err = 1'b1;
    for (int e = 0; e < cnt; e++) begin
      logic [31:0]  w[4];
      logic [127:0] line;
      int nw;
      nw = (t == 2'b00) ? 1 : 4;
      for (int k = 0; k < 4; k++) w[k] = pattern ? 32'((k + 1) * 32'h1111_1111) : $urandom;
      line = {w[0], w[1], w[2], w[3]};
      if (t == 2'b00) begin
        q_im.push_back({10'((start + e) % 1024), w[0]});
      end else if (t == 2'b01) begin
        int r;
        r = (start % 128) + e;
        if (r < 128) q_rf.push_back({10'(r), line});
        else exp_err = 1'b1;
      end else begin
        q_ls.push_back({15'(((start / 16) * 16 + 16 * e) % 32768), line});
      end
      for (int k = 0; k < nw; k++) begin
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
        send_word(w[k], gap);
      end
    end
  endtask

  task automatic settle(input string name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_imem_drained"}, 128'(q_im.size()), 128'd0);
    check({name, "_rf_drained"}, 128'(q_rf.size()), 128'd0);
    check({name, "_ls_drained"}, 128'(q_ls.size()), 128'd0);
    check({name, "_err"}, 128'(err), 128'(exp_err));
    check({name, "_core_rst"}, 128'(core_rst), 128'd1);
  endtask

  initial begin
    s_valid   = 1'b0;
    s_data    = '0;
    hold_core = 1'b0;
    exp_err   = 1'b0;
    do_reset();

    check("rst_s_ready", 128'(s_ready), 128'd1);
    check("rst_core_rst", 128'(core_rst), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_strobes", 128'({load_en, preload_en, preload_LS_en}), 128'd0);
    check("rst_outputs", 128'({instr_load_addr, preload_addr, preload_LS_addr}), 128'd0);
    check("rst_values", preload_values | preload_LS_data | 128'(instruction_in), 128'd0);

    // END straight after reset
    check("end_core_rst_before", 128'(core_rst), 128'd1);
    send_word(32'hC000_0000, 1);
    check("end_core_rst_after", 128'(core_rst), 128'd0);
    check("end_done", 128'(done), 128'd1);
    check("end_s_ready", 128'(s_ready), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    check("end_absorbing", 128'({done, core_rst}), 128'b10);
    do_reset();

    run_load(2'b00, 'h3FE, 3, 0, 1'b0);
    settle("imem_wrap");
    run_load(2'b01, 5, 1, 0, 1'b1);
    settle("rf_single");
    run_load(2'b01, 127, 2, 2, 1'b0);
    settle("rf_overflow");

    do_reset();
    run_load(2'b10, 'h7FF0, 2, 1, 1'b0);
    settle("ls_wrap_gaps");
    run_load(2'b00, 'h10, 0, 0, 1'b0);
    settle("zero_count");

    // Reset in the middle of an RF entry discards it
    do_reset();
    hold_core = 1'b1;
    send_word(mk_hdr(2'b01, 9, 1), 0);
    send_word(32'hDEAD_0001, 0);
    send_word(32'hDEAD_0002, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_err = 1'b0;
    check("midrst_core_rst", 128'(core_rst), 128'd1);
    run_load(2'b00, 'h155, 1, 0, 1'b0);
    settle("midrst_imem");
    hold_core = 1'b0;

    // Random header sequences including misaligned LS starts
    do_reset();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] t;
      t = 2'($urandom_range(0, 2));
      run_load(t, int'($urandom_range(0, 32767)), int'($urandom_range(0, 4)), 2, 1'b0);
    end
    settle("random");
    send_word(32'hC000_0000, 0);
    check("final_done", 128'(done), 128'd1);
    check("final_core_rst", 128'(core_rst), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
